vliw_writeback_bypass: RTL and testbench

- Two-slot EX→WB pipeline register for the VLIW datapath.
- Drives the register-file write ports (regWrite1/2, writeReg1/2, writeData1/2).
- Forwards in-flight results onto the four operand buses: raw register-file read data in, bypassed operands out to the ALU slots.
- Also keeps a committed-write counter for performance monitoring.

---
 rtl/vliw_pkg.sv | 16 +
 rtl/vliw_writeback_bypass_mux.sv | 42 ++++
 rtl/vliw_writeback_bypass.sv | 120 ++++++++++++
 tb/tb_vliw_writeback_bypass.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vliw_pkg.sv
// Shared VLIW datapath definitions: widths and the writeback slot bundle
// used by the EX, WB and decode stages.
package vliw_pkg;

   localparam int DATA_W = 32;   // operand/result width
   localparam int RA_W   = 3;    // register address width (8 registers)
   localparam int CNT_W  = 16;   // committed-write counter width

   // One slot's register-file write request.
   typedef struct packed {
      logic              we;
      logic [RA_W-1:0]   rd;
      logic [DATA_W-1:0] data;
   } wb_slot_t;

endpackage

// File: rtl/vliw_writeback_bypass_mux.sv
// One operand's bypass select. Newest producer wins: EX slot 2, EX slot 1,
// WB slot 2, WB slot 1, then the register-file read data. Slot 2 ranks above
// slot 1 within a stage so a same-destination bundle forwards the value the
// register file will actually keep.
module vliw_bypass_mux #(
   parameter int DATA_W = vliw_pkg::DATA_W,
   parameter int RA_W   = vliw_pkg::RA_W
) (
   input  logic [RA_W-1:0]   src,
   input  logic [DATA_W-1:0] rf,
   input  logic              exLive,
   input  logic              exWe1,
   input  logic [RA_W-1:0]   exRd1,
   input  logic [DATA_W-1:0] exRes1,
   input  logic              exWe2,
   input  logic [RA_W-1:0]   exRd2,
   input  logic [DATA_W-1:0] exRes2,
   input  logic              wbWe1,
   input  logic [RA_W-1:0]   wbRd1,
   input  logic [DATA_W-1:0] wbData1,
   input  logic              wbWe2,
   input  logic [RA_W-1:0]   wbRd2,
   input  logic [DATA_W-1:0] wbData2,
   output logic [DATA_W-1:0] fwd
);

   // Priority select of the newest in-flight value for this operand.
   always_comb begin
      // NOTE: default first so every path assigns fwd; no latch can be inferred.
      fwd = rf;
      if (exLive && exWe2 && (exRd2 == src)) begin
         fwd = exRes2;
      end else if (exLive && exWe1 && (exRd1 == src)) begin
         fwd = exRes1;
      end else if (wbWe2 && (wbRd2 == src)) begin
         fwd = wbData2;
      end else if (wbWe1 && (wbRd1 == src)) begin
         fwd = wbData1;
      end
   end

endmodule

// File: rtl/vliw_writeback_bypass.sv
// Two-slot EX->WB pipeline register for the VLIW datapath. Drives the
// register-file write ports, bypasses in-flight results onto the four
// operand buses and counts committed register writes.
module vliw_writeback_bypass #(
   parameter int DATA_W = vliw_pkg::DATA_W,
   parameter int RA_W   = vliw_pkg::RA_W,
   parameter int CNT_W  = vliw_pkg::CNT_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              ex_valid,
   input  logic              ex_we1,
   input  logic [RA_W-1:0]   ex_rd1,
   input  logic [DATA_W-1:0] ex_res1,
   input  logic              ex_we2,
   input  logic [RA_W-1:0]   ex_rd2,
   input  logic [DATA_W-1:0] ex_res2,
   input  logic              stall,
   input  logic              flush,
   input  logic [RA_W-1:0]   srcA,
   input  logic [RA_W-1:0]   srcB,
   input  logic [RA_W-1:0]   srcC,
   input  logic [RA_W-1:0]   srcD,
   input  logic [DATA_W-1:0] rfA,
   input  logic [DATA_W-1:0] rfB,
   input  logic [DATA_W-1:0] rfC,
   input  logic [DATA_W-1:0] rfD,
   output logic [DATA_W-1:0] fwdA,
   output logic [DATA_W-1:0] fwdB,
   output logic [DATA_W-1:0] fwdC,
   output logic [DATA_W-1:0] fwdD,
   output logic              regWrite1,
   output logic              regWrite2,
   output logic [RA_W-1:0]   writeReg1,
   output logic [RA_W-1:0]   writeReg2,
   output logic [DATA_W-1:0] writeData1,
   output logic [DATA_W-1:0] writeData2,
   output logic [CNT_W-1:0]  wr_count
);

   // A bundle is captured only when valid, not held and not squashed.
   // Stall and flush both turn the WB slot into a bubble.
   logic capture;
   assign capture = ex_valid & ~stall & ~flush;

   // The EX bypass ignores stall: a held bundle still carries the newest value.
   logic exLive;
   assign exLive = ex_valid & ~flush;

   // WB pipeline register; address and data load every cycle, only the
   // enables are gated so a bubble never re-writes the register file.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      if (!reset) begin
         // NOTE: address/data are cleared too so the write ports show a known
         // value out of reset, not just a deasserted enable.
         regWrite1  <= 1'b0;
         regWrite2  <= 1'b0;
         writeReg1  <= '0;
         writeReg2  <= '0;
         writeData1 <= '0;
         writeData2 <= '0;
      end else begin
         regWrite1  <= capture & ex_we1;
         regWrite2  <= capture & ex_we2;
         writeReg1  <= ex_rd1;
         writeReg2  <= ex_rd2;
         writeData1 <= ex_res1;
         writeData2 <= ex_res2;
      end
   end

   // Committed-write counter: adds the writes presented this cycle, wraps.
   always_ff @(posedge clk) begin
      if (!reset) begin
         wr_count <= '0;
      end else begin
         wr_count <= wr_count + CNT_W'(regWrite1) + CNT_W'(regWrite2);
      end
   end

   // Four identical operand bypass selects.
   vliw_bypass_mux #(.DATA_W(DATA_W), .RA_W(RA_W)) muxA (
      .src(srcA), .rf(rfA), .exLive(exLive),
      .exWe1(ex_we1), .exRd1(ex_rd1), .exRes1(ex_res1),
      .exWe2(ex_we2), .exRd2(ex_rd2), .exRes2(ex_res2),
      .wbWe1(regWrite1), .wbRd1(writeReg1), .wbData1(writeData1),
      .wbWe2(regWrite2), .wbRd2(writeReg2), .wbData2(writeData2),
      .fwd(fwdA)
   );

   vliw_bypass_mux #(.DATA_W(DATA_W), .RA_W(RA_W)) muxB (
      .src(srcB), .rf(rfB), .exLive(exLive),
      .exWe1(ex_we1), .exRd1(ex_rd1), .exRes1(ex_res1),
      .exWe2(ex_we2), .exRd2(ex_rd2), .exRes2(ex_res2),
      .wbWe1(regWrite1), .wbRd1(writeReg1), .wbData1(writeData1),
      .wbWe2(regWrite2), .wbRd2(writeReg2), .wbData2(writeData2),
      .fwd(fwdB)
   );

   vliw_bypass_mux #(.DATA_W(DATA_W), .RA_W(RA_W)) muxC (
      .src(srcC), .rf(rfC), .exLive(exLive),
      .exWe1(ex_we1), .exRd1(ex_rd1), .exRes1(ex_res1),
      .exWe2(ex_we2), .exRd2(ex_rd2), .exRes2(ex_res2),
      .wbWe1(regWrite1), .wbRd1(writeReg1), .wbData1(writeData1),
      .wbWe2(regWrite2), .wbRd2(writeReg2), .wbData2(writeData2),
      .fwd(fwdC)
   );

   vliw_bypass_mux #(.DATA_W(DATA_W), .RA_W(RA_W)) muxD (
      .src(srcD), .rf(rfD), .exLive(exLive),
      .exWe1(ex_we1), .exRd1(ex_rd1), .exRes1(ex_res1),
      .exWe2(ex_we2), .exRd2(ex_rd2), .exRes2(ex_res2),
      .wbWe1(regWrite1), .wbRd1(writeReg1), .wbData1(writeData1),
      .wbWe2(regWrite2), .wbRd2(writeReg2), .wbData2(writeData2),
      .fwd(fwdD)
   );

endmodule

// File: tb/tb_vliw_writeback_bypass.sv
// Scoreboard bench for vliw_writeback_bypass. Stimulus pushes expected
// values tagged with the cycle they must appear in; a monitor on the falling
// edge pops and compares every entry due in the current cycle.
module tb_vliw_writeback_bypass;

   localparam int DW = 32;
   localparam int AW = 3;
   localparam int CW = 4;

   logic          clk = 1'b0;
   logic          reset;
   logic          ex_valid, ex_we1, ex_we2, stall, flush;
   logic [AW-1:0] ex_rd1, ex_rd2, srcA, srcB, srcC, srcD;
   logic [DW-1:0] ex_res1, ex_res2, rfA, rfB, rfC, rfD;
   logic [DW-1:0] fwdA, fwdB, fwdC, fwdD, writeData1, writeData2;
   logic          regWrite1, regWrite2;
   logic [AW-1:0] writeReg1, writeReg2;
   logic [CW-1:0] wr_count;

   always #5 clk = ~clk;

   vliw_writeback_bypass #(.DATA_W(DW), .RA_W(AW), .CNT_W(CW)) dut (
      .clk(clk), .reset(reset), .ex_valid(ex_valid),
      .ex_we1(ex_we1), .ex_rd1(ex_rd1), .ex_res1(ex_res1),
      .ex_we2(ex_we2), .ex_rd2(ex_rd2), .ex_res2(ex_res2),
      .stall(stall), .flush(flush),
      .srcA(srcA), .srcB(srcB), .srcC(srcC), .srcD(srcD),
      .rfA(rfA), .rfB(rfB), .rfC(rfC), .rfD(rfD),
      .fwdA(fwdA), .fwdB(fwdB), .fwdC(fwdC), .fwdD(fwdD),
      .regWrite1(regWrite1), .regWrite2(regWrite2),
      .writeReg1(writeReg1), .writeReg2(writeReg2),
      .writeData1(writeData1), .writeData2(writeData2),
      .wr_count(wr_count)
   );

   typedef enum int {O_FWDA, O_FWDB, O_FWDC, O_FWDD, O_RW1, O_RW2,
                     O_WR1, O_WR2, O_WD1, O_WD2, O_CNT} sel_t;

   typedef struct {
      int          cyc;
      sel_t        sel;
      logic [31:0] val;
      string       name;
   } exp_t;

   exp_t sbq[$];
   exp_t cur;
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;

   // Reference model state for enables and the wrapping counter.
   bit   mRw1 = 1'b0, mRw2 = 1'b0;
   int   mCnt = 0;

   always @(posedge clk) cyc = cyc + 1;

   function automatic logic [31:0] outVal(sel_t s);
      case (s)
         O_FWDA:  return fwdA;
         O_FWDB:  return fwdB;
         O_FWDC:  return fwdC;
         O_FWDD:  return fwdD;
         O_RW1:   return 32'(regWrite1);
         O_RW2:   return 32'(regWrite2);
         O_WR1:   return 32'(writeReg1);
         O_WR2:   return 32'(writeReg2);
         O_WD1:   return writeData1;
         O_WD2:   return writeData2;
         default: return 32'(wr_count);
      endcase
   endfunction

   // Monitor: compare every expectation due this cycle, away from the edge.
   always @(negedge clk) begin
      while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
         cur = sbq.pop_front();
         checks++;
         if (cur.cyc != cyc || outVal(cur.sel) !== cur.val) begin
            errors++;
            $display("FAIL %s (due cycle %0d, seen cycle %0d): got %h expected %h",
                     cur.name, cur.cyc, cyc, outVal(cur.sel), cur.val);
         end
      end
   end

   // Insert keeping the queue ordered by due cycle.
   task automatic push(int when, sel_t s, logic [31:0] v, string n);
      exp_t e;
      int   idx;
      e = '{when, s, v, n};
      idx = sbq.size();
      for (int i = 0; i < sbq.size(); i++) begin
         if (sbq[i].cyc > when) begin
            idx = i;
            break;
         end
      end
      sbq.insert(idx, e);
   endtask

   task automatic expectNow(sel_t s, logic [31:0] v, string n);
      push(cyc, s, v, n);
   endtask

   task automatic expectNext(sel_t s, logic [31:0] v, string n);
      push(cyc + 1, s, v, n);
   endtask

   task automatic nextCycle();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      reset = 1'b1; ex_valid = 1'b0; stall = 1'b0; flush = 1'b0;
      ex_we1 = 1'b0; ex_we2 = 1'b0; ex_rd1 = '0; ex_rd2 = '0;
      ex_res1 = '0; ex_res2 = '0;
   endtask

   // Advance the model for the edge ending this cycle; expect enables/count.
   task automatic endCycle();
      bit cap;
      cap = ex_valid & ~stall & ~flush;
      if (!reset) begin
         mCnt = 0; mRw1 = 1'b0; mRw2 = 1'b0;
      end else begin
         mCnt = (mCnt + int'(mRw1) + int'(mRw2)) % (1 << CW);
         mRw1 = cap & ex_we1;
         mRw2 = cap & ex_we2;
      end
      expectNext(O_RW1, 32'(mRw1), "regWrite1");
      expectNext(O_RW2, 32'(mRw2), "regWrite2");
      expectNext(O_CNT, 32'(mCnt), "wr_count");
   endtask

   initial begin
      idle();
      srcA = '0; srcB = '0; srcC = '0; srcD = '0;
      rfA = '0; rfB = '0; rfC = '0; rfD = '0;

      // Reset held two cycles while EX offers a write.
      reset = 1'b0; ex_valid = 1'b1; ex_we1 = 1'b1; ex_rd1 = 3'd1; ex_res1 = 32'h5;
      endCycle();
      nextCycle();
      endCycle();
      expectNext(O_WR1, 32'h0, "reset writeReg1");
      expectNext(O_WD1, 32'h0, "reset writeData1");
      expectNext(O_WD2, 32'h0, "reset writeData2");

      // Basic write, slot 1 -> r3; EX bypass on A, passthrough on B.
      nextCycle();
      idle();
      ex_valid = 1'b1; ex_we1 = 1'b1; ex_rd1 = 3'd3; ex_res1 = 32'h1234_5678;
      srcA = 3'd3; srcB = 3'd4; rfB = 32'hB0B0_B0B0;
      expectNow(O_FWDA, 32'h1234_5678, "basic EX fwdA");
      expectNow(O_FWDB, 32'hB0B0_B0B0, "basic passthrough fwdB");
      endCycle();
      expectNext(O_WR1, 32'd3, "basic writeReg1");
      expectNext(O_WD1, 32'h1234_5678, "basic writeData1");

      // Same destination r5 in both slots: slot 2 wins; WB slot1 r3 on B.
      nextCycle();
      idle();
      ex_valid = 1'b1; ex_we1 = 1'b1; ex_rd1 = 3'd5; ex_res1 = 32'hAAAA;
      ex_we2 = 1'b1; ex_rd2 = 3'd5; ex_res2 = 32'hBBBB;
      srcA = 3'd5; rfA = 32'h0; srcB = 3'd3; rfB = 32'h0;
      expectNow(O_FWDA, 32'hBBBB, "samedst EX fwdA");
      expectNow(O_FWDB, 32'h1234_5678, "WB slot1 fwdB");
      endCycle();
      expectNext(O_WR1, 32'd5, "samedst writeReg1");
      expectNext(O_WR2, 32'd5, "samedst writeReg2");
      expectNext(O_WD1, 32'hAAAA, "samedst writeData1");
      expectNext(O_WD2, 32'hBBBB, "samedst writeData2");

      nextCycle();
      idle();
      expectNow(O_FWDA, 32'hBBBB, "samedst WB fwdA");
      endCycle();

      nextCycle();
      idle();
      rfA = 32'hBBBB;
      expectNow(O_FWDA, 32'hBBBB, "samedst committed fwdA");
      endCycle();

      // Priority: WB r2=0x11, then EX r2=0x22 beats it.
      nextCycle();
      idle();
      ex_valid = 1'b1; ex_we1 = 1'b1; ex_rd1 = 3'd2; ex_res1 = 32'h11;
      srcB = 3'd2; rfB = 32'h0;
      expectNow(O_FWDB, 32'h11, "prio EX r2=11");
      endCycle();

      nextCycle();
      ex_res1 = 32'h22;
      expectNow(O_FWDB, 32'h22, "prio EX over WB");
      endCycle();

      nextCycle();
      idle();
      expectNow(O_FWDB, 32'h22, "prio WB fwdB");
      endCycle();

      nextCycle();
      rfB = 32'h33;
      expectNow(O_FWDB, 32'h33, "prio passthrough fwdB");
      endCycle();

      // Stall: EX bypass still active, WB gets a bubble.
      nextCycle();
      idle();
      ex_valid = 1'b1; ex_we2 = 1'b1; ex_rd2 = 3'd7; ex_res2 = 32'h99; stall = 1'b1;
      srcC = 3'd7; rfC = 32'h44;
      expectNow(O_FWDC, 32'h99, "stall EX fwdC");
      endCycle();

      // Flush: no EX bypass, bubble.
      nextCycle();
      stall = 1'b0; flush = 1'b1;
      srcD = 3'd7; rfD = 32'h55;
      expectNow(O_FWDC, 32'h44, "flush fwdC");
      expectNow(O_FWDD, 32'h55, "flush fwdD");
      endCycle();

      // Stall and flush together.
      nextCycle();
      stall = 1'b1;
      expectNow(O_FWDC, 32'h44, "stall+flush fwdC");
      endCycle();

      // Flush with no valid bundle.
      nextCycle();
      stall = 1'b0; ex_valid = 1'b0;
      expectNow(O_FWDC, 32'h44, "flush idle fwdC");
      endCycle();

      // Register 0 is ordinary.
      nextCycle();
      idle();
      ex_valid = 1'b1; ex_we2 = 1'b1; ex_rd2 = 3'd0; ex_res2 = 32'hDEAD;
      srcD = 3'd0; rfD = 32'h1;
      expectNow(O_FWDD, 32'hDEAD, "r0 EX fwdD");
      endCycle();
      expectNext(O_WR2, 32'd0, "r0 writeReg2");
      expectNext(O_WD2, 32'hDEAD, "r0 writeData2");

      // EX slot 2 beats WB slot 2 on the same register.
      nextCycle();
      ex_res2 = 32'hBEEF;
      expectNow(O_FWDD, 32'hBEEF, "EX over WB fwdD");
      endCycle();

      nextCycle();
      idle();
      expectNow(O_FWDD, 32'hBEEF, "WB slot2 fwdD");
      endCycle();

      // Eight dual-write bundles walk the 4-bit counter through its wrap.
      for (int i = 0; i < 8; i++) begin
         nextCycle();
         idle();
         ex_valid = 1'b1; ex_we1 = 1'b1; ex_we2 = 1'b1;
         ex_rd1 = AW'(i); ex_rd2 = AW'(i + 1);
         ex_res1 = 32'(i); ex_res2 = 32'(i + 100);
         endCycle();
      end

      // Reset mid-stall wins over everything.
      nextCycle();
      reset = 1'b0; stall = 1'b1;
      endCycle();
      expectNext(O_WD1, 32'h0, "midstall reset writeData1");
      expectNext(O_WD2, 32'h0, "midstall reset writeData2");

      nextCycle();
      idle();
      endCycle();
      nextCycle();
      endCycle();

      // Drain the scoreboard within a bounded number of cycles.
      for (int i = 0; i < 10 && sbq.size() > 0; i++) begin
         @(negedge clk);
         #1;
      end
      if (sbq.size() > 0) begin
         errors++;
         $display("FAIL scoreboard drain: got %0d pending expected 0", sbq.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
